regfile_mp: RTL

//  Parametrised multi-port integer register file with write-to-read bypass and a
//  per-register busy scoreboard. Successor to the single-write/dual-read core RF.

---
 rtl/rf_pkg.sv | 20 ++
 rtl/rf_scoreboard.sv | 77 +++++++
 rtl/regfile_mp.sv | 111 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared definitions for the multi-port register file.
// Contents:
//   XLEN_DEF / NREGS_DEF  default data width and register count
//   clog2_safe            address width helper that never returns 0
//   reg_addr_t            register address type for the default configuration
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;

    // A one-register file still needs a one-bit address bus.
    function automatic int clog2_safe(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int AW_DEF = clog2_safe(NREGS_DEF);

    typedef logic [AW_DEF-1:0] reg_addr_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard for the register file.
// One busy bit per architectural register. A bit is set by a reserve, cleared
// by a write to that register, and the whole vector is cleared by flush.
// Priority per register: flush > reserve > write release > hold.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   we, waddr           write ports (release the addressed register)
//   rsv_valid, rsv_addr reserve request
//   flush               clear every busy bit at the edge
//   raddr               read port addresses
//   rbusy               registered busy bit of each read port's register
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = clog2_safe(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic              rsv_valid,
    input  logic [AW-1:0]     rsv_addr,
    input  logic              flush,
    input  logic [NRD*AW-1:0] raddr,
    output logic [NRD-1:0]    rbusy
);

    // Register 0 never gets a busy bit when it is hardwired to zero.
    localparam int FIRST_REG = (ZERO_REG != 0) ? 1 : 0;

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             release_s;
    logic             reserve_s;

    // Next busy vector. Looping over legal registers only means out-of-range
    // addresses and a zero-register address simply never match.
    always_comb begin
        busy_d    = {NREGS{1'b0}};
        release_s = 1'b0;
        reserve_s = 1'b0;
        for (int r = FIRST_REG; r < NREGS; r++) begin
            release_s = 1'b0;
            for (int i = 0; i < NWR; i++) begin
                release_s = release_s | (we[i] & (waddr[i*AW +: AW] == AW'(r)));
            end
            reserve_s = rsv_valid & (rsv_addr == AW'(r));
            busy_d[r] = flush     ? 1'b0 :
                        reserve_s ? 1'b1 :
                        release_s ? 1'b0 : busy_q[r];
        end
    end

    // Busy state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= {NREGS{1'b0}};
        end else begin
            busy_q <= busy_d;
        end
    end

    // Registered-only lookup: same-cycle reserves/releases are not forwarded.
    always_comb begin
        rbusy = {NRD{1'b0}};
        for (int j = 0; j < NRD; j++) begin
            for (int r = FIRST_REG; r < NREGS; r++) begin
                rbusy[j] = (raddr[j*AW +: AW] == AW'(r)) ? busy_q[r] : rbusy[j];
            end
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and busy scoreboard.
// Decode reads operands and reserves destinations; writeback writes and releases.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   we/waddr/wdata      NWR write ports, packed, port i at [i*W +: W]
//   raddr/rdata         NRD combinational read ports, packed the same way
//   rbusy               pending-write status of each read port's register
//   rsv_valid/rsv_addr  mark a register busy
//   flush               clear all busy bits at the edge
module regfile_mp
    import rf_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 1,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = clog2_safe(NREGS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NWR-1:0]      we,
    input  logic [NWR*AW-1:0]   waddr,
    input  logic [NWR*XLEN-1:0] wdata,
    input  logic [NRD*AW-1:0]   raddr,
    output logic [NRD*XLEN-1:0] rdata,
    output logic [NRD-1:0]      rbusy,
    input  logic                rsv_valid,
    input  logic [AW-1:0]       rsv_addr,
    input  logic                flush
);

    // Register 0 is excluded from storage updates when hardwired to zero.
    localparam int FIRST_REG = (ZERO_REG != 0) ? 1 : 0;

    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];
    logic [XLEN-1:0] rd_s;
    logic            ra_ok_s;
    logic [AW-1:0]   ra_s;

    // Write merge: ascending port order, so the highest index wins a conflict.
    // Out-of-range and zero-register addresses never match a loop index.
    always_comb begin
        for (int r = 0; r < NREGS; r++) begin
            regs_d[r] = regs_q[r];
        end
        for (int r = FIRST_REG; r < NREGS; r++) begin
            for (int i = 0; i < NWR; i++) begin
                regs_d[r] = (we[i] && (waddr[i*AW +: AW] == AW'(r)))
                          ? wdata[i*XLEN +: XLEN] : regs_d[r];
            end
        end
    end

    // Data array storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= {XLEN{1'b0}};
            end
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                regs_q[r] <= regs_d[r];
            end
        end
    end

    // Read mux plus optional same-cycle bypass. ra_ok_s marks a writable,
    // in-range address; only those may be bypassed, everything else reads 0.
    always_comb begin
        rdata   = {(NRD*XLEN){1'b0}};
        rd_s    = {XLEN{1'b0}};
        ra_ok_s = 1'b0;
        ra_s    = {AW{1'b0}};
        for (int j = 0; j < NRD; j++) begin
            ra_s    = raddr[j*AW +: AW];
            rd_s    = {XLEN{1'b0}};
            ra_ok_s = 1'b0;
            for (int r = FIRST_REG; r < NREGS; r++) begin
                rd_s    = (ra_s == AW'(r)) ? regs_q[r] : rd_s;
                ra_ok_s = ra_ok_s | (ra_s == AW'(r));
            end
            for (int i = 0; i < NWR; i++) begin
                rd_s = ((BYPASS != 0) && ra_ok_s && we[i] && (waddr[i*AW +: AW] == ra_s))
                     ? wdata[i*XLEN +: XLEN] : rd_s;
            end
            rdata[j*XLEN +: XLEN] = rd_s;
        end
    end

    rf_scoreboard #(
        .NREGS    (NREGS),
        .NRD      (NRD),
        .NWR      (NWR),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_scoreboard (
        .clk       (clk),
        .rst_n     (rst_n),
        .we        (we),
        .waddr     (waddr),
        .rsv_valid (rsv_valid),
        .rsv_addr  (rsv_addr),
        .flush     (flush),
        .raddr     (raddr),
        .rbusy     (rbusy)
    );

endmodule
